// File: rtl/init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : init_sequencer
// Purpose  : Power-up and link bring-up sequencer for a video transmitter.
//            Waits for PLL lock, lets supplies settle, pulses the transmitter
//            reset, starts the configuration engine (with bounded retries),
//            and then enables the video path. A PLL unlock at any point after
//            lock restarts the bring-up. Repeated configuration failures land
//            in a sticky FAULT state that only reset can leave.
// Revision : 1.0 - initial release
// ============================================================================
module init_sequencer #(
  parameter int unsigned CLK_FREQ_HZ    = 27000000,
  parameter int unsigned PWR_SETTLE_MS  = 200,
  parameter int unsigned RESET_HOLD_MS  = 10,
  parameter int unsigned POST_RESET_MS  = 50,
  parameter int unsigned CFG_TIMEOUT_MS = 100,
  parameter int unsigned RETRY_MAX      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       hpd,
  input  logic       cfg_done,
  input  logic       cfg_error,
  output logic       tx_reset_n,
  output logic       cfg_start,
  output logic       video_enable,
  output logic       fault,
  output logic [2:0] state,
  output logic [1:0] retry_count
);

  // --------------------------------------------------------------------------
  // Timing constants
  // --------------------------------------------------------------------------
  // The millisecond-to-cycle product overflows 32 bits for realistic clock
  // rates and delays, so it is formed in 64 bits before the divide.
  function automatic logic [31:0] last_count(input logic [63:0] cycles);
    logic [31:0] result;
    if (cycles == 64'd0) begin
      // A zero-length interval still has to occupy the state for one cycle.
      result = 32'd0;
    end else if (cycles > 64'h0000_0001_0000_0000) begin
      // Longer than the counter can express: clamp to the longest wait.
      result = 32'hFFFF_FFFF;
    end else begin
      result = 32'(cycles - 64'd1);
    end
    return result;
  endfunction

  localparam logic [63:0] c_SETTLE_CYC64 =
    (64'(CLK_FREQ_HZ) * 64'(PWR_SETTLE_MS)) / 64'd1000;
  localparam logic [63:0] c_HOLD_CYC64 =
    (64'(CLK_FREQ_HZ) * 64'(RESET_HOLD_MS)) / 64'd1000;
  localparam logic [63:0] c_POST_CYC64 =
    (64'(CLK_FREQ_HZ) * 64'(POST_RESET_MS)) / 64'd1000;
  localparam logic [63:0] c_CFG_CYC64 =
    (64'(CLK_FREQ_HZ) * 64'(CFG_TIMEOUT_MS)) / 64'd1000;

  // Counter value on the final cycle of each timed state.
  localparam logic [31:0] c_SETTLE_LAST = last_count(c_SETTLE_CYC64);
  localparam logic [31:0] c_HOLD_LAST   = last_count(c_HOLD_CYC64);
  localparam logic [31:0] c_POST_LAST   = last_count(c_POST_CYC64);
  localparam logic [31:0] c_CFG_LAST    = last_count(c_CFG_CYC64);

  localparam logic [1:0]  c_RETRY_CEIL  = 2'b11;

  // --------------------------------------------------------------------------
  // State encoding (visible on the state output, so values are fixed)
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_SETTLE     = 3'd1,
    ST_TX_RESET   = 3'd2,
    ST_POST_RESET = 3'd3,
    ST_CFG_START  = 3'd4,
    ST_CFG_WAIT   = 3'd5,
    ST_RUN        = 3'd6,
    ST_FAULT      = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  retry_q, retry_d;
  logic        tx_reset_n_q, tx_reset_n_d;
  logic        cfg_start_q, cfg_start_d;
  logic        video_enable_q, video_enable_d;
  logic        fault_q, fault_d;

  logic        retry_allowed;
  logic        lock_lost;

  // Another configuration attempt is allowed while below the retry limit; the
  // extra ceiling test keeps the 2-bit counter from wrapping if RETRY_MAX is
  // set larger than the counter can hold.
  assign retry_allowed = (32'(retry_q) < RETRY_MAX) && (retry_q != c_RETRY_CEIL);

  // Losing lock restarts bring-up from every state except the two where the
  // sequencer is either already waiting for lock or latched in fault.
  assign lock_lost = !pll_locked &&
                     (state_q != ST_WAIT_LOCK) && (state_q != ST_FAULT);

  // Next-state and retry bookkeeping.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (pll_locked) begin
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (count_q == c_SETTLE_LAST) begin
          state_d = ST_TX_RESET;
        end
      end

      ST_TX_RESET: begin
        if (count_q == c_HOLD_LAST) begin
          state_d = ST_POST_RESET;
        end
      end

      ST_POST_RESET: begin
        if (count_q == c_POST_LAST) begin
          state_d = ST_CFG_START;
        end
      end

      ST_CFG_START: begin
        // Hold off configuration until a sink is attached.
        if (hpd) begin
          state_d = ST_CFG_WAIT;
        end
      end

      ST_CFG_WAIT: begin
        // Success is checked first so that it wins over an error or a
        // timeout landing on the same cycle.
        if (cfg_done) begin
          state_d = ST_RUN;
          retry_d = 2'd0;
        end else if (cfg_error || (count_q == c_CFG_LAST)) begin
          if (retry_allowed) begin
            state_d = ST_CFG_START;
            retry_d = retry_q + 2'd1;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end

      ST_RUN: begin
        // Sink unplugged: reconfigure without replaying the reset sequence.
        if (!hpd) begin
          state_d = ST_CFG_START;
          retry_d = 2'd0;
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_WAIT_LOCK;
        retry_d = 2'd0;
      end
    endcase

    if (lock_lost) begin
      state_d = ST_WAIT_LOCK;
      retry_d = 2'd0;
    end
  end

  // Shared interval counter: restarts at zero on every state change and
  // holds at its maximum in untimed states rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (state_d != state_q) begin
      count_d = 32'd0;
    end else if (count_q != 32'hFFFF_FFFF) begin
      count_d = count_q + 32'd1;
    end
  end

  // Output decode from the upcoming state so every output is a flop that
  // lines up with the registered state it belongs to.
  always_comb begin
    tx_reset_n_d   = 1'b1;
    cfg_start_d    = 1'b0;
    video_enable_d = 1'b0;
    fault_d        = 1'b0;

    case (state_d)
      ST_WAIT_LOCK,
      ST_SETTLE,
      ST_TX_RESET: begin
        tx_reset_n_d = 1'b0;
      end
      ST_RUN: begin
        video_enable_d = 1'b1;
      end
      ST_FAULT: begin
        tx_reset_n_d = 1'b0;
        fault_d      = 1'b1;
      end
      default: begin
        tx_reset_n_d = 1'b1;
      end
    endcase

    // Single-cycle start pulse on the first cycle of each configuration wait.
    if ((state_q == ST_CFG_START) && (state_d == ST_CFG_WAIT)) begin
      cfg_start_d = 1'b1;
    end
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_WAIT_LOCK;
      count_q        <= 32'd0;
      retry_q        <= 2'd0;
      tx_reset_n_q   <= 1'b0;
      cfg_start_q    <= 1'b0;
      video_enable_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      retry_q        <= retry_d;
      tx_reset_n_q   <= tx_reset_n_d;
      cfg_start_q    <= cfg_start_d;
      video_enable_q <= video_enable_d;
      fault_q        <= fault_d;
    end
  end

  assign tx_reset_n   = tx_reset_n_q;
  assign cfg_start    = cfg_start_q;
  assign video_enable = video_enable_q;
  assign fault        = fault_q;
  assign state        = state_q;
  assign retry_count  = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_init_sequencer
// Purpose  : Directed scoreboard bench for init_sequencer. Stimulus queues
//            per-cycle output snapshots and cfg_start pulse times; a monitor
//            on the falling edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_init_sequencer;

  localparam int ST_WL  = 0;
  localparam int ST_SET = 1;
  localparam int ST_TXR = 2;
  localparam int ST_PR  = 3;
  localparam int ST_CS  = 4;
  localparam int ST_CW  = 5;
  localparam int ST_RUN = 6;
  localparam int ST_FLT = 7;

  logic       clock;
  logic       reset;
  logic       pll_locked;
  logic       hpd;
  logic       cfg_done;
  logic       cfg_error;
  logic       tx_reset_n;
  logic       cfg_start;
  logic       video_enable;
  logic       fault;
  logic [2:0] state;
  logic [1:0] retry_count;

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] st;
    logic       txn;
    logic       cs;
    logic       ve;
    logic       f;
    logic [1:0] rc;
  } snap_t;

  snap_t exp_q[$];
  int    pulse_q[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  init_sequencer #(
    .CLK_FREQ_HZ   (1000),
    .PWR_SETTLE_MS (4),
    .RESET_HOLD_MS (2),
    .POST_RESET_MS (3),
    .CFG_TIMEOUT_MS(10),
    .RETRY_MAX     (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .hpd         (hpd),
    .cfg_done    (cfg_done),
    .cfg_error   (cfg_error),
    .tx_reset_n  (tx_reset_n),
    .cfg_start   (cfg_start),
    .video_enable(video_enable),
    .fault       (fault),
    .state       (state),
    .retry_count (retry_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle index: number of rising edges seen so far.
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare queued snapshots due this cycle and every cfg_start pulse.
  always @(negedge clock) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        checks++;
        if ({state, tx_reset_n, cfg_start, video_enable, fault, retry_count} !==
            {exp_q[i].st, exp_q[i].txn, exp_q[i].cs, exp_q[i].ve, exp_q[i].f, exp_q[i].rc}) begin
          errors++;
          $display("FAIL %s @cyc %0d: got st=%0d txn=%0b cs=%0b ve=%0b f=%0b rc=%0d, expected st=%0d txn=%0b cs=%0b ve=%0b f=%0b rc=%0d",
                   exp_q[i].name, cyc, state, tx_reset_n, cfg_start, video_enable, fault, retry_count,
                   exp_q[i].st, exp_q[i].txn, exp_q[i].cs, exp_q[i].ve, exp_q[i].f, exp_q[i].rc);
        end
        exp_q.delete(i);
      end
    end
    if (cfg_start === 1'b1) begin
      int idx;
      idx = -1;
      for (int i = 0; i < pulse_q.size(); i++) begin
        if (pulse_q[i] == cyc) idx = i;
      end
      checks++;
      if (idx < 0) begin
        errors++;
        $display("FAIL cfg_start_pulse: got pulse at cyc %0d, expected none", cyc);
      end else begin
        pulse_q.delete(idx);
      end
    end
  end

  task automatic expect_at(input int c, input string nm, input int st, input bit txn,
                           input bit cs, input bit ve, input bit f, input int rc);
    snap_t s;
    s.cyc  = c;
    s.name = nm;
    s.st   = 3'(st);
    s.txn  = txn;
    s.cs   = cs;
    s.ve   = ve;
    s.f    = f;
    s.rc   = 2'(rc);
    exp_q.push_back(s);
  endtask

  task automatic expect_pulse(input int c);
    pulse_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    int s, r, w, f, s2, s3, s4, s5;
    reset = 1'b0; pll_locked = 1'b0; hpd = 1'b0; cfg_done = 1'b0; cfg_error = 1'b0;
    repeat (3) tick();
    expect_at(cyc, "reset_state", ST_WL, 0, 0, 0, 0, 0);
    reset = 1'b1;
    hpd   = 1'b1;
    tick();
    expect_at(cyc, "wait_lock_idle", ST_WL, 0, 0, 0, 0, 0);

    // Nominal bring-up
    pll_locked = 1'b1;
    s = cyc + 1;
    expect_at(s,      "settle_entry",    ST_SET, 0, 0, 0, 0, 0);
    expect_at(s + 3,  "settle_last",     ST_SET, 0, 0, 0, 0, 0);
    expect_at(s + 4,  "txreset_entry",   ST_TXR, 0, 0, 0, 0, 0);
    expect_at(s + 5,  "txreset_last",    ST_TXR, 0, 0, 0, 0, 0);
    expect_at(s + 6,  "post_reset_entry", ST_PR, 1, 0, 0, 0, 0);
    expect_at(s + 8,  "post_reset_last", ST_PR,  1, 0, 0, 0, 0);
    expect_at(s + 9,  "cfg_start_state", ST_CS,  1, 0, 0, 0, 0);
    expect_at(s + 10, "cfg_start_pulse", ST_CW,  1, 1, 0, 0, 0);
    expect_pulse(s + 10);
    expect_at(s + 11, "cfg_start_drop",  ST_CW,  1, 0, 0, 0, 0);
    expect_at(s + 16, "run_entry",       ST_RUN, 1, 0, 1, 0, 0);
    wait_until(s + 15);
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;

    // Unplug in RUN, replug 20 cycles later, then let every attempt time out
    r = s + 20;
    expect_at(r,      "run_steady",      ST_RUN, 1, 0, 1, 0, 0);
    expect_at(r + 1,  "hpd_low_restart", ST_CS,  1, 0, 0, 0, 0);
    expect_at(r + 21, "hpd_wait_no_replay", ST_CS, 1, 0, 0, 0, 0);
    w = r + 22;
    expect_at(w,      "replug_pulse",    ST_CW,  1, 1, 0, 0, 0);
    expect_pulse(w);
    expect_at(w + 9,  "timeout_last",    ST_CW,  1, 0, 0, 0, 0);
    expect_at(w + 10, "retry1_start",    ST_CS,  1, 0, 0, 0, 1);
    expect_at(w + 11, "retry1_pulse",    ST_CW,  1, 1, 0, 0, 1);
    expect_pulse(w + 11);
    expect_at(w + 21, "retry2_start",    ST_CS,  1, 0, 0, 0, 2);
    expect_at(w + 22, "retry2_pulse",    ST_CW,  1, 1, 0, 0, 2);
    expect_pulse(w + 22);
    expect_at(w + 31, "final_wait_last", ST_CW,  1, 0, 0, 0, 2);
    expect_at(w + 32, "fault_entry",     ST_FLT, 0, 0, 0, 1, 2);
    expect_at(w + 36, "fault_ignores_lock", ST_FLT, 0, 0, 0, 1, 2);
    expect_at(w + 40, "fault_sticky",    ST_FLT, 0, 0, 0, 1, 2);
    wait_until(r);
    hpd = 1'b0;
    wait_until(r + 21);
    hpd = 1'b1;
    wait_until(w + 34);
    pll_locked = 1'b0;
    cfg_done   = 1'b1;
    tick();
    cfg_done = 1'b0;
    wait_until(w + 38);
    pll_locked = 1'b1;

    // Reset out of FAULT
    f  = w + 42;
    s2 = f + 2;
    expect_at(f + 1,   "reset_from_fault", ST_WL, 0, 0, 0, 0, 0);
    expect_at(s2,      "settle_again",    ST_SET, 0, 0, 0, 0, 0);
    expect_at(s2 + 2,  "settle_ignores_err", ST_SET, 0, 0, 0, 0, 0);
    expect_at(s2 + 4,  "txreset_on_time", ST_TXR, 0, 0, 0, 0, 0);
    expect_at(s2 + 10, "pulse_after_fault", ST_CW, 1, 1, 0, 0, 0);
    expect_pulse(s2 + 10);
    expect_at(s2 + 13, "error_retry",     ST_CS,  1, 0, 0, 0, 1);
    expect_at(s2 + 14, "error_retry_pulse", ST_CW, 1, 1, 0, 0, 1);
    expect_pulse(s2 + 14);
    expect_at(s2 + 16, "cfg_wait_before_unlock", ST_CW, 1, 0, 0, 0, 1);
    expect_at(s2 + 17, "unlock_beats_done", ST_WL, 0, 0, 0, 0, 0);
    wait_until(f);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wait_until(s2 + 1);
    cfg_error = 1'b1;
    tick();
    cfg_error = 1'b0;
    wait_until(s2 + 12);
    cfg_error = 1'b1;
    tick();
    cfg_error = 1'b0;
    wait_until(s2 + 16);
    pll_locked = 1'b0;
    cfg_done   = 1'b1;
    tick();
    cfg_done   = 1'b0;
    pll_locked = 1'b1;

    // Done and error together, then reset in RUN and in the pulse cycle
    s3 = s2 + 18;
    expect_at(s3,      "relock_settle",   ST_SET, 0, 0, 0, 0, 0);
    expect_at(s3 + 10, "pulse_s3",        ST_CW,  1, 1, 0, 0, 0);
    expect_pulse(s3 + 10);
    expect_at(s3 + 14, "done_beats_error", ST_RUN, 1, 0, 1, 0, 0);
    expect_at(s3 + 18, "reset_in_run",    ST_WL,  0, 0, 0, 0, 0);
    s4 = s3 + 19;
    expect_at(s4 + 9,  "cfg_start_before_reset", ST_CS, 1, 0, 0, 0, 0);
    expect_at(s4 + 10, "reset_kills_pulse", ST_WL, 0, 0, 0, 0, 0);
    wait_until(s3 + 13);
    cfg_done  = 1'b1;
    cfg_error = 1'b1;
    tick();
    cfg_done  = 1'b0;
    cfg_error = 1'b0;
    wait_until(s3 + 17);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wait_until(s4 + 9);
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // Success on the timeout cycle still wins
    s5 = s4 + 11;
    expect_at(s5,      "settle_s5",       ST_SET, 0, 0, 0, 0, 0);
    expect_at(s5 + 10, "pulse_s5",        ST_CW,  1, 1, 0, 0, 0);
    expect_pulse(s5 + 10);
    expect_at(s5 + 20, "done_beats_timeout", ST_RUN, 1, 0, 1, 0, 0);
    wait_until(s5 + 19);
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
    wait_until(s5 + 24);
    #6;

    foreach (exp_q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: got no sample at cyc %0d, expected one", exp_q[i].name, exp_q[i].cyc);
    end
    foreach (pulse_q[i]) begin
      checks++;
      errors++;
      $display("FAIL cfg_start_pulse: got none at cyc %0d, expected pulse", pulse_q[i]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/init_sequencer.md
INIT_SEQUENCER -- requirements
Module: init_sequencer

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 27000000, clock frequency in Hz.
REQ-002 SHALL have parameter PWR_SETTLE_MS, default 200, settle time after PLL lock.
REQ-003 SHALL have parameter RESET_HOLD_MS, default 10, transmitter reset assertion time.
REQ-004 SHALL have parameter POST_RESET_MS, default 50, wait between reset release and configuration.
REQ-005 SHALL have parameter CFG_TIMEOUT_MS, default 100, maximum wait for configuration completion.
REQ-006 SHALL have parameter RETRY_MAX, default 3, number of configuration retries before fault.
REQ-007 SHALL have port clock  input  1  system clock; all logic on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-009 SHALL have port pll_locked  input  1  pixel PLL lock; already synchronous to clock.
REQ-010 SHALL have port hpd  input  1  hot-plug detect; already synchronous to clock.
REQ-011 SHALL have port cfg_done  input  1  one-cycle pulse from configuration engine: success.
REQ-012 SHALL have port cfg_error  input  1  one-cycle pulse from configuration engine: failure.
REQ-013 SHALL have port tx_reset_n  output  1  active-low transmitter reset.
REQ-014 SHALL have port cfg_start  output  1  one-cycle configuration start pulse.
REQ-015 SHALL have port video_enable  output  1  enables video output path.
REQ-016 SHALL have port fault  output  1  sticky failure flag.
REQ-017 SHALL have port state  output  3  current state encoding.
REQ-018 SHALL have port retry_count  output  2  configuration retries used.

Function
REQ-019 SHALL encode states: 0 WAIT_LOCK, 1 SETTLE, 2 TX_RESET, 3 POST_RESET, 4 CFG_START, 5 CFG_WAIT, 6 RUN, 7 FAULT; state output is registered state.
REQ-020 SHALL use one 32-bit cycle counter, cleared on every state entry; timed state T exits when counter == CLK_FREQ_HZ*T_MS/1000 - 1, i.e. occupies exactly CLK_FREQ_HZ*T_MS/1000 cycles; product computed at elaboration in ≥64 bits.
REQ-021 WAIT_LOCK: pll_locked high -> SETTLE next cycle.
REQ-022 SETTLE: PWR_SETTLE_MS elapsed -> TX_RESET.
REQ-023 TX_RESET: tx_reset_n low for entire state; RESET_HOLD_MS elapsed -> POST_RESET.
REQ-024 POST_RESET: POST_RESET_MS elapsed -> CFG_START.
REQ-025 CFG_START: waits while hpd low; first cycle with hpd high -> cfg_start high for that single registered cycle, then CFG_WAIT.
REQ-026 CFG_WAIT: cfg_done -> RUN, retry_count cleared; cfg_error or CFG_TIMEOUT_MS elapsed -> CFG_START if retry_count < RETRY_MAX (retry_count+1), else FAULT; cfg_done wins over simultaneous cfg_error or timeout.
REQ-027 RUN: video_enable high; hpd low -> CFG_START, video_enable low next cycle, retry_count cleared.
REQ-028 FAULT: tx_reset_n low, video_enable low, fault high; exits only via reset.
REQ-029 pll_locked low in any state except WAIT_LOCK and FAULT -> WAIT_LOCK next cycle, overriding all other transitions; retry_count cleared.
REQ-030 tx_reset_n SHALL be low in WAIT_LOCK, SETTLE, TX_RESET, FAULT; high otherwise.
REQ-031 cfg_done/cfg_error outside CFG_WAIT SHALL be ignored.
REQ-032 All outputs SHALL be registered; no combinational input-to-output paths.
REQ-033 retry_count SHALL saturate at RETRY_MAX and never wrap.

Reset
REQ-034 reset low at a rising edge SHALL force, next cycle: state WAIT_LOCK, counter 0, tx_reset_n 0, cfg_start 0, video_enable 0, fault 0, retry_count 0.
REQ-035 reset mid-operation (any state, including cfg_start cycle) SHALL abort immediately; reset dominates all inputs.

Verification (CLK_FREQ_HZ=1000, PWR_SETTLE_MS=4, RESET_HOLD_MS=2, POST_RESET_MS=3, CFG_TIMEOUT_MS=10, RETRY_MAX=2)
REQ-036 hpd=1, pll_locked rises cycle 0 -> SETTLE 4 cycles, tx_reset_n low 6 cycles total from SETTLE entry, rises entering POST_RESET, cfg_start pulse after 3 POST_RESET cycles; cfg_done 5 cycles later -> RUN, video_enable=1.
REQ-037 No cfg_done/cfg_error -> three cfg_start pulses 11 cycles apart, retry_count 0->1->2, then FAULT: fault=1, tx_reset_n=0, state=7 until reset.
REQ-038 hpd low in RUN -> state 4, video_enable=0 next cycle; hpd high 20 cycles later -> cfg_start same cycle-plus-one, no reset-sequence replay.
REQ-039 pll_locked drops in CFG_WAIT with cfg_done same cycle -> WAIT_LOCK, tx_reset_n=0, retry_count=0.
REQ-040 cfg_done and cfg_error same cycle in CFG_WAIT -> RUN; reset pulsed in RUN -> all outputs at REQ-034 values next cycle.
